dsc_mul_seq: RTL and testbench
==============================

DSC_MUL_SEQ -- requirements
Module: dsc_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; legal range 2..8.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  operand pair a/b is valid.
REQ-005 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-006 SHALL have port a  in  WIDTH  unsigned operand A.
REQ-007 SHALL have port b  in  WIDTH  unsigned operand B.
REQ-008 SHALL have port out_valid  out  1  result is valid.
REQ-009 SHALL have port out_ready  in  1  consumer accepts result.
REQ-010 SHALL have port result  out  2*WIDTH  product a*b, exact.
REQ-011 SHALL have port sn_y  out  1  current product bitstream bit, for debug; 0 outside RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and HOLD.
REQ-013 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-014 SHALL, on a posedge in IDLE with in_valid=1, capture a/b into internal registers, clear the 2*WIDTH-bit sequence counter ctr and the accumulator acc, and go to RUN.
REQ-015 SHALL drive in_ready=0 in RUN and HOLD, and SHALL ignore in_valid in those states.
REQ-016 SHALL, in RUN, form sn_a = (a_reg > ctr[WIDTH-1:0]) and sn_b = (b_reg > ctr[2*WIDTH-1:WIDTH]) (clock-division deterministic streams), and sn_y = sn_a & sn_b.
REQ-017 SHALL, on each RUN posedge, add sn_y to acc and increment ctr.
REQ-018 SHALL stay in RUN for exactly T = 2^(2*WIDTH) cycles.
REQ-019 SHALL, on the RUN posedge where ctr == T-1, perform the final acc update, wrap ctr to 0 and go to HOLD.
REQ-020 SHALL raise out_valid exactly T cycles after the accepting edge.
REQ-021 SHALL make acc 2*WIDTH bits wide; the final value equals a*b exactly (max (2^WIDTH-1)^2 < 2^(2*WIDTH)), so no overflow is possible.
REQ-022 SHALL, in HOLD, drive out_valid=1 with result=acc and hold both stable until out_ready=1.
REQ-023 SHALL, on a HOLD posedge with out_ready=1, go to IDLE.
REQ-024 SHALL drive out_valid low in the following cycle.
REQ-025 SHALL keep result holding the last product until the next RUN completes.
REQ-026 SHALL ignore out_ready outside HOLD.
REQ-027 SHALL give a=0 or b=0 the full T-cycle run and result 0; there is no early exit.
REQ-028 SHALL ensure that changes on a/b after capture do not affect the running product.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, ctr=0, acc=0, a_reg=0, b_reg=0, out_valid=0, result=0 and sn_y=0, with in_ready=1 after rst deasserts.
REQ-030 SHALL treat rst asserted mid-RUN or mid-HOLD as aborting the operation, with no out_valid pulse produced.

Structure
REQ-031 SHALL take FSM state encodings (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and the T/counter-width derivation from shared package dsc_pkg.
REQ-032 SHALL contain one sub-module, dsc_sn_gen, which holds ctr and the two comparators and outputs sn_a, sn_b and the ctr-terminal flag.
REQ-033 SHALL keep the FSM, operand registers and accumulator in dsc_mul_seq itself.

Verification
REQ-034 SHALL cover: WIDTH=4, a=9, b=6 accepted at edge E0 -> out_valid rises at E0+256, result=54, sum of sn_y over RUN=54.
REQ-035 SHALL cover: a=15, b=15 -> result=225; a=0, b=15 -> result=0 after the full 256 cycles.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in HOLD -> out_valid=1, result constant and in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 SHALL cover: in_valid pulsed with a=3, b=3 during RUN of a=9, b=6 -> ignored, result=54.
REQ-038 SHALL cover: rst pulsed at RUN cycle 100 -> out_valid=0, result=0, in_ready=1 after release; new pair a=5, b=7 -> result=35.
REQ-039 SHALL cover: exhaustive sweep of all a, b at WIDTH=4 with random out_ready stalls -> result==a*b for every pair.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic multiplier: FSM encodings
// and the sequence-counter width / run-length derivation from operand width.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 8;

    // One counter bit per bit of both operands: low half walks sn_a, high half walks sn_b.
    function automatic int ctr_width(input int width);
        return 2 * width;
    endfunction

    function automatic longint run_len(input int width);
        return longint'(1) << (2 * width);
    endfunction

endpackage

// File: rtl/dsc_sn_gen.sv
// Clock-division bitstream generator: a 2*WIDTH-bit sequence counter whose low half
// is compared against operand A and whose high half is compared against operand B.
module dsc_sn_gen
    import dsc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a_reg,
    input  logic [WIDTH-1:0] b_reg,
    output logic             sn_a,
    output logic             sn_b,
    output logic             term
);

    localparam int CW = ctr_width(WIDTH);

    logic [CW-1:0] ctr;

    // Wraps to zero naturally on the terminal increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr <= '0;
        end else if (clr) begin
            ctr <= '0;
        end else if (en) begin
            ctr <= ctr + 1'b1;
        end
    end

    assign sn_a = (a_reg > ctr[WIDTH-1:0]);
    assign sn_b = (b_reg > ctr[CW-1:WIDTH]);
    assign term = &ctr;

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequential unsigned multiplier: counts coincident ones of two deterministic
// bitstreams over a full 2^(2*WIDTH)-cycle run, giving the exact product.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | streams active, accumulating sn_a & sn_b for T cycles
// HOLD  | product presented on result, waiting for out_ready
module dsc_mul_seq
    import dsc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               sn_y
);

    localparam int CW = ctr_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    result_q;
    logic [CW-1:0]    acc_next;
    logic             sn_a;
    logic             sn_b;
    logic             term;
    logic             accept;
    logic             run_en;

    dsc_sn_gen #(
        .WIDTH (WIDTH)
    ) u_sn_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (run_en),
        .a_reg (a_reg),
        .b_reg (b_reg),
        .sn_a  (sn_a),
        .sn_b  (sn_b),
        .term  (term)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        run_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (term) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign sn_y     = run_en & sn_a & sn_b;
    assign acc_next = acc + {{(CW-1){1'b0}}, sn_y};
    assign result   = result_q;

    // result_q is separate from acc so the previous product survives the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                acc   <= '0;
            end
            if (run_en) begin
                acc <= acc_next;
                if (term) begin
                    result_q <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Scoreboard bench for dsc_mul_seq at WIDTH=4: the driver queues expected products,
// the monitor checks each output handshake, latency, stream sum and hold stability.
module tb_dsc_mul_seq;

    localparam int W = 4;
    localparam int T = 256;

    typedef struct {
        logic [7:0] prod;
        int         acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   result;
    logic         sn_y;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    exp_t sb[$];

    dsc_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sn_y      (sn_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares on the first HOLD cycle, then checks stability and the post-handshake drop.
    initial begin : monitor
        exp_t       e;
        bit         seen = 1'b0;
        bit         prev_hs = 1'b0;
        int         sn_sum = 0;
        logic [7:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen    = 1'b0;
                prev_hs = 1'b0;
                sn_sum  = 0;
            end else begin
                if (prev_hs) begin
                    chk(out_valid == 1'b0, "out_valid_drop", out_valid, 0);
                    chk(in_ready == 1'b1, "in_ready_after_hs", in_ready, 1);
                end
                if (out_valid && !seen) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_output", result, -1);
                    end else begin
                        e = sb.pop_front();
                        chk(result == e.prod, "result", result, e.prod);
                        chk(cyc == e.acc_cyc + T, "latency", cyc - e.acc_cyc, T);
                        chk(sn_sum == int'(e.prod), "sn_y_sum", sn_sum, e.prod);
                    end
                    held   = result;
                    seen   = 1'b1;
                    sn_sum = 0;
                end else if (out_valid) begin
                    chk(result == held, "hold_stable", result, held);
                    chk(in_ready == 1'b0, "hold_in_ready", in_ready, 0);
                end
                if (!out_valid) seen = 1'b0;
                sn_sum += int'(sn_y);
                case (rdy_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                prev_hs = out_valid && out_ready;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit push);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk(1'b0, "in_ready_timeout", in_ready, 1);
            return;
        end
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        if (push) sb.push_back('{8'(aa) * 8'(bb), cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(sb.size() == 0 && in_ready, "drain_timeout", sb.size(), 0);
    endtask

    initial begin : watchdog
        #(10 * 95000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        repeat (3) @(negedge clk);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(result == 8'd0, "rst_result", result, 0);
        chk(sn_y == 1'b0, "rst_sn_y", sn_y, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);

        // 9*6 with an ignored 3*3 request during RUN
        issue(4'd9, 4'd6, 1'b1);
        repeat (50) @(negedge clk);
        chk(in_ready == 1'b0, "run_in_ready", in_ready, 0);
        a = 4'd3; b = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // 15*15 with a 10-cycle out_ready stall
        rdy_mode = 0;
        issue(4'd15, 4'd15, 1'b1);
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid == 1'b1, "stall_wait", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk(out_valid == 1'b1, "stall_out_valid", out_valid, 1);
            chk(result == 8'd225, "stall_result", result, 225);
            chk(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
        end
        rdy_mode = 1;
        drain();

        issue(4'd0, 4'd15, 1'b1);
        drain();
        chk(result == 8'd0, "zero_result_held", result, 0);

        // abort mid-RUN by reset, then a fresh operation
        issue(4'd9, 4'd6, 1'b0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
        chk(result == 8'd0, "abort_result", result, 0);
        chk(sn_y == 1'b0, "abort_sn_y", sn_y, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "abort_in_ready", in_ready, 1);
        chk(out_valid == 1'b0, "abort_no_pulse", out_valid, 0);
        issue(4'd5, 4'd7, 1'b1);
        drain();
        chk(result == 8'd35, "post_abort_result", result, 35);

        // exhaustive sweep with random out_ready stalls
        rdy_mode = 2;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue(W'(i), W'(j), 1'b1);
            end
        end
        drain();
        rdy_mode = 1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
